// File: rtl/uart_emitter_fifo.sv
// uart_emitter_fifo: byte FIFO draining into an 8N1 serial emitter.
// Optional build macro UART_EMITTER_FIFO_LEVEL_EN adds o_level (registered occupancy).
//
// Emitter states:
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | line held high, waiting for a byte in the FIFO
//   ST_FRAME | shifting start, eight data (LSB first) and stop bits
//
// bit_idx_q walks 0 (start), 1..8 (data), 9 (stop); each bit lasts DIV cycles.
module uart_emitter_fifo #(
   parameter int clk_freq_hz = 100000000,
   parameter int baud_rate   = 1000000,
   parameter int DEPTH       = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_full,
   output logic       o_empty,
   output logic       o_busy,
   output logic       o_uart_tx
`ifdef UART_EMITTER_FIFO_LEVEL_EN
   ,
   output logic [$clog2(DEPTH):0] o_level
`endif
);

   localparam int DIV = clk_freq_hz / baud_rate;
   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BW-1:0] BAUD_RELOAD = BW'(DIV - 1);
   localparam logic [CW-1:0] COUNT_FULL  = CW'(DEPTH);

   typedef enum logic {
      ST_IDLE,
      ST_FRAME
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            full_q, full_d;
   logic            empty_q, empty_d;
   logic [7:0]      shift_q, shift_d;
   logic [3:0]      bit_idx_q, bit_idx_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic            tx_q, tx_d;
   logic            push;
   logic            pop;
   logic            bit_end;

   // Next-state logic for FIFO bookkeeping and the emitter FSM.
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      baud_d    = baud_q;
      tx_d      = tx_q;

      // Acceptance uses the registered full flag, so a pop in the same
      // cycle never rescues a write that arrives while full.
      push    = i_valid && !full_q && !i_rst;
      bit_end = (state_q == ST_FRAME) && (baud_q == '0);
      // Loading on the final stop-bit cycle gives gapless back-to-back frames.
      pop     = !empty_q && ((state_q == ST_IDLE) || (bit_end && (bit_idx_q == 4'd9)));

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == COUNT_FULL);
      empty_d = (count_d == '0);

      if (pop) begin
         state_d   = ST_FRAME;
         shift_d   = mem_q[rd_ptr_q];
         bit_idx_d = 4'd0;
         baud_d    = BAUD_RELOAD;
         tx_d      = 1'b0;
      end else if (bit_end) begin
         baud_d = BAUD_RELOAD;
         if (bit_idx_q == 4'd9) begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q == 4'd8) begin
               tx_d = 1'b1;
            end else begin
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
            end
         end
      end else if (state_q == ST_FRAME) begin
         baud_d = baud_q - 1'b1;
      end
   end

   // State and control registers with synchronous reset; reset aborts any frame.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         shift_q   <= '0;
         bit_idx_q <= '0;
         baud_q    <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         baud_q    <= baud_d;
         tx_q      <= tx_d;
      end
   end

   // FIFO storage; contents need no reset since the pointers gate every read.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

   assign o_full    = full_q;
   assign o_empty   = empty_q;
   assign o_busy    = (state_q == ST_FRAME);
   assign o_uart_tx = tx_q;
`ifdef UART_EMITTER_FIFO_LEVEL_EN
   assign o_level   = count_q;
`endif

endmodule

// File: tb/tb_uart_emitter_fifo.sv
// Directed bench for uart_emitter_fifo: three instances (DIV=16/DEPTH=16,
// DIV=16/DEPTH=4, default parameters) sharing one clock and reset.
module tb_uart_emitter_fifo;

   logic       clk;
   logic       rst;
   logic [7:0] data_a, data_b, data_c;
   logic       valid_a, valid_b, valid_c;
   logic       full_a, full_b, full_c;
   logic       empty_a, empty_b, empty_c;
   logic       busy_a, busy_b, busy_c;
   logic       tx_a, tx_b, tx_c;
`ifdef UART_EMITTER_FIFO_LEVEL_EN
   logic [4:0] lvl_a;
   logic [2:0] lvl_b;
   logic [4:0] lvl_c;
`endif

   int n_chk = 0;
   int n_err = 0;

   uart_emitter_fifo #(.clk_freq_hz(16), .baud_rate(1), .DEPTH(16)) u_a (
      .i_clk(clk), .i_rst(rst), .i_data(data_a), .i_valid(valid_a),
      .o_full(full_a), .o_empty(empty_a), .o_busy(busy_a), .o_uart_tx(tx_a)
`ifdef UART_EMITTER_FIFO_LEVEL_EN
      , .o_level(lvl_a)
`endif
   );

   uart_emitter_fifo #(.clk_freq_hz(16), .baud_rate(1), .DEPTH(4)) u_b (
      .i_clk(clk), .i_rst(rst), .i_data(data_b), .i_valid(valid_b),
      .o_full(full_b), .o_empty(empty_b), .o_busy(busy_b), .o_uart_tx(tx_b)
`ifdef UART_EMITTER_FIFO_LEVEL_EN
      , .o_level(lvl_b)
`endif
   );

   uart_emitter_fifo u_c (
      .i_clk(clk), .i_rst(rst), .i_data(data_c), .i_valid(valid_c),
      .o_full(full_c), .o_empty(empty_c), .o_busy(busy_c), .o_uart_tx(tx_c)
`ifdef UART_EMITTER_FIFO_LEVEL_EN
      , .o_level(lvl_c)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic tx_of(input int idx);
      case (idx)
         0:       return tx_a;
         1:       return tx_b;
         default: return tx_c;
      endcase
   endfunction

   function automatic logic busy_of(input int idx);
      case (idx)
         0:       return busy_a;
         1:       return busy_b;
         default: return busy_c;
      endcase
   endfunction

   // Expected line level for bit k of a frame: start, LSB-first data, stop.
   function automatic logic exp_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return b[k-1];
   endfunction

   // Called c0 cycles after the load edge; checks first and last cycle of every bit
   // and returns on the last cycle of the stop bit.
   task automatic frame(input int idx, input int div, input logic [7:0] b, input int c0);
      for (int c = c0; c < 10 * div; c++) begin
         if (c > c0) tick();
         if ((c % div == 0) || (c % div == div - 1))
            chk($sformatf("u%0d_byte%02h_bit%0d_c%0d", idx, b, c / div, c), tx_of(idx), exp_bit(b, c / div));
      end
      chk($sformatf("u%0d_busy_stop_last", idx), busy_of(idx), 1);
   endtask

   task automatic watch_idle(input int idx, input int n);
      int bad = 0;
      repeat (n) begin
         tick();
         if (tx_of(idx) !== 1'b1 || busy_of(idx) !== 1'b0) bad++;
      end
      chk($sformatf("u%0d_idle_line", idx), bad, 0);
   endtask

   initial begin
      rst = 1'b1;
      valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
      data_a = 8'h00; data_b = 8'h00; data_c = 8'h00;
      repeat (3) tick();
      rst = 1'b0;

      // Reset state
      chk("rst_tx_a", tx_a, 1);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_empty_a", empty_a, 1);
      chk("rst_full_a", full_a, 0);
      chk("rst_empty_b", empty_b, 1);
      chk("rst_tx_c", tx_c, 1);
      chk("rst_busy_c", busy_c, 0);
`ifdef UART_EMITTER_FIFO_LEVEL_EN
      chk("rst_level_a", lvl_a, 0);
`endif
      watch_idle(0, 20);

      // Single byte 0x55: write edge N, load edge N+1
      data_a = 8'h55; valid_a = 1'b1;
      tick();
      valid_a = 1'b0;
      chk("single_empty_after_write", empty_a, 0);
      chk("single_busy_after_write", busy_a, 0);
      chk("single_tx_after_write", tx_a, 1);
      tick();
      chk("single_busy_after_load", busy_a, 1);
      chk("single_empty_after_load", empty_a, 1);
      frame(0, 16, 8'h55, 0);
      tick();
      chk("single_busy_end", busy_a, 0);
      chk("single_tx_end", tx_a, 1);
      watch_idle(0, 20);

      // Back-to-back 0x00, 0xFF; second write lands on the load edge (count 1 -> 1)
      data_a = 8'h00; valid_a = 1'b1;
      tick();
      data_a = 8'hFF;
      tick();
      valid_a = 1'b0;
      chk("pushpop_empty", empty_a, 0);
      chk("pushpop_full", full_a, 0);
      chk("pushpop_busy", busy_a, 1);
`ifdef UART_EMITTER_FIFO_LEVEL_EN
      chk("pushpop_level", lvl_a, 1);
`endif
      frame(0, 16, 8'h00, 0);
      tick();
      chk("b2b_busy_second_load", busy_a, 1);
      chk("b2b_empty_second_load", empty_a, 1);
      frame(0, 16, 8'hFF, 0);
      tick();
      chk("b2b_busy_end", busy_a, 0);
      chk("b2b_empty_end", empty_a, 1);
      watch_idle(0, 40);

      // Full: DEPTH=4, six consecutive writes 0x01..0x06
      for (int i = 0; i < 6; i++) begin
         data_b = 8'(i + 1); valid_b = 1'b1;
         tick();
         chk($sformatf("full_after_write%0d", i + 1), full_b, (i >= 4) ? 1 : 0);
      end
      valid_b = 1'b0;
      chk("full_busy", busy_b, 1);
`ifdef UART_EMITTER_FIFO_LEVEL_EN
      chk("full_level", lvl_b, 4);
`endif
      frame(1, 16, 8'h01, 4);
      for (int k = 2; k <= 5; k++) begin
         tick();
         if (k == 2) chk("full_drops_after_pop", full_b, 0);
         frame(1, 16, 8'(k), 0);
      end
      tick();
      chk("full_busy_end", busy_b, 0);
      chk("full_empty_end", empty_b, 1);
      watch_idle(1, 200);

      // Reset mid-frame with a second byte buffered; write during reset ignored
      data_a = 8'hA5; valid_a = 1'b1;
      tick();
      data_a = 8'h3C;
      tick();
      valid_a = 1'b0;
      repeat (38) tick();
      chk("midrst_busy_before", busy_a, 1);
      rst = 1'b1; valid_a = 1'b1; data_a = 8'hFF;
      tick();
      rst = 1'b0; valid_a = 1'b0;
      chk("midrst_tx", tx_a, 1);
      chk("midrst_busy", busy_a, 0);
      chk("midrst_empty", empty_a, 1);
      chk("midrst_full", full_a, 0);
      watch_idle(0, 200);
      chk("midrst_empty_after", empty_a, 1);

      // Default parameters: DIV=100, frame 1000 cycles
      data_c = 8'hC3; valid_c = 1'b1;
      tick();
      valid_c = 1'b0;
      tick();
      chk("dflt_busy_load", busy_c, 1);
      frame(2, 100, 8'hC3, 0);
      tick();
      chk("dflt_busy_end", busy_c, 0);
      chk("dflt_tx_end", tx_c, 1);
      watch_idle(2, 20);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
